pipe_stage_skid: RTL and testbench

Generic, parametrised pipeline stage register for the RISC-V core, successor to the fixed-field per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a packed payload of DATA_W bits with a valid/ready handshake and a two-entry skid buffer, so upstream sees a registered ready with no combinational path from out_ready_i. Separate hold (stall_i) and kill (flush_i) controls replace the old "stall or flush ⇒ bubble" behaviour. A programmable bubble pattern is driven whenever the stage is empty. Saturating stall and flush event counters feed the didactic debug view.

---
 rtl/pipe_stage_skid_pkg.sv | 20 ++
 rtl/pipe_sat_counter.sv | 41 ++++
 rtl/pipe_stage_skid.sv | 132 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy
// encoding and a helper that builds it from the two valid flags.
package pipe_stage_skid_pkg;

    // Occupancy is encoded directly as {skid_valid, main_valid}, so the
    // state needs no separate register and can never disagree with the flags.
    typedef logic [1:0] occ_t;

    localparam logic [1:0] OCC_EMPTY = 2'b00;
    localparam logic [1:0] OCC_ONE   = 2'b01;
    localparam logic [1:0] OCC_TWO   = 2'b11;

    // Number of bits needed for a per-cycle counter increment (0, 1 or 2).
    localparam int INC_W = 2;

    function automatic occ_t occ_of(input logic main_valid, input logic skid_valid);
        return {skid_valid, main_valid};
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: adds 0..3 per enabled cycle and sticks at the
// all-ones value instead of wrapping. Cleared only by reset.
module pipe_sat_counter
    import pipe_stage_skid_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_en_i,
    input  logic [INC_W-1:0] inc_amt_i,
    output logic [W-1:0]     count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W+1:0] sum;
    logic [W+1:0] max_val;

    // Widen by two bits so the overflow is visible before clamping.
    always_comb begin
        max_val = {2'b00, {W{1'b1}}};
        sum     = {2'b00, count_q} + {{W{1'b0}}, inc_amt_i};
        count_d = count_q;
        if (inc_en_i) begin
            count_d = (sum > max_val) ? {W{1'b1}} : sum[W-1:0];
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a two-entry skid buffer. Ready and
// valid toward the neighbours come only from registered state and stall_i,
// so there is no combinational path from out_ready_i to in_ready_o.
// Flush beats stall beats handshake.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W     = 128,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    logic              in_fire;
    logic              out_fire;
    occ_t              occ;
    logic [INC_W-1:0]  flush_amt;

    assign in_ready_o  = !skid_valid_q && !stall_i;
    assign out_valid_o = main_valid_q && !stall_i;
    // Bubble is shown whenever nothing is being offered, including while stalled.
    assign out_data_o  = out_valid_o ? main_q : BUBBLE_VAL;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;
    assign occ      = occ_of(main_valid_q, skid_valid_q);

    // Next-state for the occupancy flags and the two data slots.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d       = BUBBLE_VAL;
            skid_d       = BUBBLE_VAL;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_valid_d = 1'b1;
                        main_d       = in_data_i;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        skid_valid_d = 1'b1;
                        skid_d       = in_data_i;
                    end else if (out_fire) begin
                        main_valid_d = 1'b0;
                        main_d       = BUBBLE_VAL;
                    end
                end
                OCC_TWO: begin
                    // in_ready_o is low here, so only the output side can move.
                    if (out_fire) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                        skid_d       = BUBBLE_VAL;
                    end
                end
                default: begin
                    // Skid-without-main cannot be reached; recover to empty.
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                    main_d       = BUBBLE_VAL;
                    skid_d       = BUBBLE_VAL;
                end
            endcase
        end
    end

    // State registers; reset drops every entry immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= BUBBLE_VAL;
            skid_q       <= BUBBLE_VAL;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    // A flush discards however many valid entries are currently held.
    assign flush_amt = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    pipe_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .inc_en_i  (stall_i && main_valid_q),
        .inc_amt_i (2'd1),
        .count_o   (stall_cnt_o)
    );

    pipe_sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .inc_en_i  (flush_i),
        .inc_amt_i (flush_amt),
        .count_o   (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid. Two instances share all inputs: one with
// 16-bit counters and one with 2-bit counters to exercise saturation.
module tb_pipe_stage_skid;

    logic        clk;
    logic        reset_n;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        out_ready_i;
    logic        stall_i;
    logic        flush_i;

    logic        in_ready_o;
    logic        out_valid_o;
    logic [7:0]  out_data_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    logic        s_in_ready_o;
    logic        s_out_valid_o;
    logic [7:0]  s_out_data_o;
    logic [1:0]  s_stall_cnt_o;
    logic [1:0]  s_flush_cnt_o;

    int total;
    int bad;

    pipe_stage_skid #(
        .DATA_W     (8),
        .BUBBLE_VAL (8'hA5),
        .CNT_W      (16)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    pipe_stage_skid #(
        .DATA_W     (8),
        .BUBBLE_VAL (8'hA5),
        .CNT_W      (2)
    ) u_sat (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (s_in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (s_out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (s_out_data_o),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .stall_cnt_o (s_stall_cnt_o),
        .flush_cnt_o (s_flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and
    // outputs sampled well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 8'h00;
        out_ready_i = 1'b0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_data", 32'(out_data_o), 32'hA5);
        check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        $display("txn reset: out_valid=%0d out_data=%0h in_ready=%0d", out_valid_o, out_data_o, in_ready_o);
        reset_n = 1'b1;
        tick();

        // Stream 0x01..0x10 with downstream always ready: one per cycle, 1-cycle latency
        out_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(i);
            settle();
            check("stream_in_ready", 32'(in_ready_o), 32'd1);
            tick();
            check("stream_out_valid", 32'(out_valid_o), 32'd1);
            check("stream_out_data", 32'(out_data_o), 32'(i));
            $display("txn stream: sent=%0h out_data=%0h", i, out_data_o);
        end
        in_valid_i = 1'b0;
        tick();
        check("stream_drained", 32'(out_valid_o), 32'd0);
        check("stream_bubble", 32'(out_data_o), 32'hA5);

        // Backpressure: downstream stalls while upstream keeps offering
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'h21;
        tick();
        in_data_i   = 8'h22;
        settle();
        check("bp_ready_one", 32'(in_ready_o), 32'd1);
        tick();
        in_data_i   = 8'h23;
        settle();
        check("bp_ready_two", 32'(in_ready_o), 32'd0);
        tick();
        check("bp_hold_ready", 32'(in_ready_o), 32'd0);
        check("bp_hold_data", 32'(out_data_o), 32'h21);
        $display("txn backpressure: held head=%0h in_ready=%0d", out_data_o, in_ready_o);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        settle();
        check("bp_drain0", 32'(out_data_o), 32'h21);
        tick();
        check("bp_drain1_valid", 32'(out_valid_o), 32'd1);
        check("bp_drain1", 32'(out_data_o), 32'h22);
        check("bp_refill_ready", 32'(in_ready_o), 32'd1);
        tick();
        check("bp_empty", 32'(out_valid_o), 32'd0);
        $display("txn drain: out_valid=%0d", out_valid_o);

        // Stall 5 cycles with one entry held
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'h33;
        tick();
        in_valid_i  = 1'b0;
        stall_i     = 1'b1;
        out_ready_i = 1'b1;
        settle();
        check("stall_out_valid", 32'(out_valid_o), 32'd0);
        check("stall_out_data", 32'(out_data_o), 32'hA5);
        check("stall_in_ready", 32'(in_ready_o), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("stall_cnt5", 32'(stall_cnt_o), 32'd5);
        check("stall_sat_cnt", 32'(s_stall_cnt_o), 32'd3);
        stall_i = 1'b0;
        settle();
        check("stall_release_valid", 32'(out_valid_o), 32'd1);
        check("stall_release_data", 32'(out_data_o), 32'h33);
        $display("txn stall: cnt=%0d released=%0h", stall_cnt_o, out_data_o);
        tick();
        check("stall_after_empty", 32'(out_valid_o), 32'd0);

        // Flush in TWO with a pending input
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'h41;
        tick();
        in_data_i   = 8'h42;
        tick();
        in_data_i   = 8'h43;
        flush_i     = 1'b1;
        tick();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        settle();
        check("flush_out_valid", 32'(out_valid_o), 32'd0);
        check("flush_out_data", 32'(out_data_o), 32'hA5);
        check("flush_cnt2", 32'(flush_cnt_o), 32'd2);
        check("flush_sat_cnt2", 32'(s_flush_cnt_o), 32'd2);
        check("flush_in_ready", 32'(in_ready_o), 32'd1);
        $display("txn flush: flush_cnt=%0d out_data=%0h", flush_cnt_o, out_data_o);

        // Flush while empty discards a same-cycle accepted input, counter unchanged
        in_valid_i = 1'b1;
        in_data_i  = 8'h44;
        flush_i    = 1'b1;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        settle();
        check("flush_empty_valid", 32'(out_valid_o), 32'd0);
        check("flush_empty_cnt", 32'(flush_cnt_o), 32'd2);
        $display("txn flush_empty: out_valid=%0d flush_cnt=%0d", out_valid_o, flush_cnt_o);

        // Long stall: wide counter keeps counting, narrow one stays saturated
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'h55;
        tick();
        in_valid_i  = 1'b0;
        stall_i     = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("sat_wide_cnt", 32'(stall_cnt_o), 32'd15);
        check("sat_narrow_cnt", 32'(s_stall_cnt_o), 32'd3);
        stall_i     = 1'b0;
        out_ready_i = 1'b1;
        settle();
        check("sat_release_data", 32'(out_data_o), 32'h55);
        $display("txn saturate: wide=%0d narrow=%0d", stall_cnt_o, s_stall_cnt_o);

        // Reset mid-operation: entries dropped at once, counters cleared
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'h66;
        tick();
        reset_n = 1'b0;
        settle();
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_data", 32'(out_data_o), 32'hA5);
        check("mid_rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check("mid_rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
        $display("txn mid_reset: out_valid=%0d counters=%0d/%0d", out_valid_o, stall_cnt_o, flush_cnt_o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
